// File: rtl/dsc_bs2bin_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsc_bs2bin_acc_if
//  Brief    : Bitstream-to-binary converter bus (bitstream, control, result)
//  Revision : 1.0  initial release
// ============================================================================
interface dsc_bs2bin_acc_if #(
    parameter int DATAWD = 8
);
    logic              iBit;
    logic              start;
    logic              iClr;
    logic              oLoad;
    logic              oBusy;
    logic              oValid;
    logic [DATAWD-1:0] oData;

    // master: controlling logic / upstream multiplier side
    modport master (
        output iBit,
        output start,
        output iClr,
        input  oLoad,
        input  oBusy,
        input  oValid,
        input  oData
    );

    modport slave (
        input  iBit,
        input  start,
        input  iClr,
        output oLoad,
        output oBusy,
        output oValid,
        output oData
    );
endinterface
`default_nettype wire

// File: rtl/dsc_bs2bin_acc.sv
`default_nettype none
// ============================================================================
//  Module   : dsc_bs2bin_acc
//  Brief    : Counts ones of a stochastic bitstream over a 2^WINLOG window and
//             returns the scaled, saturated DATAWD-bit binary value.
//  Revision : 1.0  initial release
// ============================================================================
module dsc_bs2bin_acc #(
    parameter int DATAWD = 8,
    parameter int WINLOG = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dsc_bs2bin_acc_if.slave   bus
);

    generate
        if (WINLOG < DATAWD) begin : g_param_check
            $error("dsc_bs2bin_acc: WINLOG must be >= DATAWD");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WINLOG:0]   c_win_len  = {1'b1, {WINLOG{1'b0}}};
    localparam logic [WINLOG-1:0] c_cnt_one  = {{(WINLOG-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [WINLOG:0]     acc_q, acc_d;
    logic [WINLOG-1:0]   win_cnt_q, win_cnt_d;
    logic [DATAWD-1:0]   data_q, data_d;

    logic [WINLOG:0]     w_acc_sum;
    logic                w_last;
    logic [DATAWD-1:0]   w_scaled;

    // Sum including the current sample so the final bit lands in the result.
    assign w_acc_sum = acc_q + {{WINLOG{1'b0}}, bus.iBit};
    assign w_last    = &win_cnt_q;
    // A full window of ones would wrap the top-bits slice to zero, so saturate.
    assign w_scaled  = (w_acc_sum == c_win_len) ? {DATAWD{1'b1}}
                                                : w_acc_sum[WINLOG-1 -: DATAWD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            win_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            win_cnt_q <= win_cnt_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        win_cnt_d = win_cnt_q;
        data_d    = data_q;

        if (bus.iClr) begin
            state_d   = ST_IDLE;
            acc_d     = '0;
            win_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    acc_d     = '0;
                    win_cnt_d = '0;
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    acc_d     = w_acc_sum;
                    win_cnt_d = win_cnt_q + c_cnt_one;
                    if (w_last) begin
                        data_d  = w_scaled;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oLoad  = (state_q == ST_LOAD);
    assign bus.oValid = (state_q == ST_DONE);
    assign bus.oBusy  = (state_q != ST_IDLE);
    assign bus.oData  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_dsc_bs2bin_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dsc_bs2bin_acc
//  Brief    : Scoreboard bench for dsc_bs2bin_acc (WINLOG=8 and WINLOG=10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsc_bs2bin_acc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic stim_bit    = 1'b0;
    logic stim_clr    = 1'b0;
    logic stim_start0 = 1'b0;
    logic stim_start1 = 1'b0;

    dsc_bs2bin_acc_if #(.DATAWD(8)) if0 ();
    dsc_bs2bin_acc_if #(.DATAWD(8)) if1 ();

    assign if0.iBit  = stim_bit;
    assign if0.iClr  = stim_clr;
    assign if0.start = stim_start0;
    assign if1.iBit  = stim_bit;
    assign if1.iClr  = stim_clr;
    assign if1.start = stim_start1;

    dsc_bs2bin_acc #(.DATAWD(8), .WINLOG(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    dsc_bs2bin_acc #(.DATAWD(8), .WINLOG(10)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         n_cmp = 0;
    int         n_err = 0;
    chk_t       mon_c;
    logic [7:0] mon_e;

    // Monitor: results against the expected-result queues, plus queued point checks.
    always @(negedge clk) begin
        if (rst_n && if0.oValid) begin
            n_cmp++;
            if (exp_q0.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid0: got oValid=1 with oData=%0d, expected no result", if0.oData);
            end else begin
                mon_e = exp_q0.pop_front();
                if (if0.oData !== mon_e) begin
                    n_err++;
                    $display("FAIL data0: got %0d expected %0d", if0.oData, mon_e);
                end
            end
        end
        if (rst_n && if1.oValid) begin
            n_cmp++;
            if (exp_q1.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid1: got oValid=1 with oData=%0d, expected no result", if1.oData);
            end else begin
                mon_e = exp_q1.pop_front();
                if (if1.oData !== mon_e) begin
                    n_err++;
                    $display("FAIL data1: got %0d expected %0d", if1.oData, mon_e);
                end
            end
        end
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            n_cmp++;
            if (mon_c.act !== mon_c.exp) begin
                n_err++;
                $display("FAIL %s: got %0d expected %0d", mon_c.name, mon_c.act, mon_c.exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_load(input int which);
        return (which == 0) ? if0.oLoad : if1.oLoad;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? if0.oBusy : if1.oBusy;
    endfunction

    function automatic logic get_valid(input int which);
        return (which == 0) ? if0.oValid : if1.oValid;
    endfunction

    function automatic logic [7:0] get_data(input int which);
        return (which == 0) ? if0.oData : if1.oData;
    endfunction

    task automatic drive_start(input int which, input logic v);
        if (which == 0) stim_start0 = v;
        else            stim_start1 = v;
    endtask

    // mode 0: all zeros, 1: first m bits one, 2: alternating starting with one
    function automatic logic pat(input int mode, input int k, input int m);
        case (mode)
            1:       return (k < m);
            2:       return ((k % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_window(input int which, input int mode, input int m,
                              input logic [7:0] exp, input int hold, input logic noisy);
        int n;
        n = (which == 0) ? 256 : 1024;
        if (which == 0) exp_q0.push_back(exp);
        else            exp_q1.push_back(exp);
        drive_start(which, 1'b1);
        step();
        drive_start(which, noisy);
        check("load_pulse", 32'(get_load(which)), 32'd1);
        check("busy_in_load", 32'(get_busy(which)), 32'd1);
        step();
        check("load_one_cycle", 32'(get_load(which)), 32'd0);
        for (int k = 0; k < n; k++) begin
            stim_bit = pat(mode, k, m);
            if (noisy) drive_start(which, (k % 50) == 7);
            if (hold >= 0 && k == 10) check("data_hold", 32'(get_data(which)), 32'(hold));
            step();
        end
        stim_bit = 1'b0;
        drive_start(which, noisy);
        check("valid_latency", 32'(get_valid(which)), 32'd1);
        step();
        drive_start(which, 1'b0);
        check("busy_after_done", 32'(get_busy(which)), 32'd0);
    endtask

    task automatic idle_watch(input int which, input int cycles, input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (get_valid(which)) cnt++;
        end
        check(name, 32'(cnt), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(if0.oData), 32'd0);
        check("rst_busy", 32'(if0.oBusy), 32'd0);
        check("rst_valid", 32'(if0.oValid), 32'd0);
        check("rst_load", 32'(if0.oLoad), 32'd0);
        check("rst_data_w10", 32'(if1.oData), 32'd0);
        rst_n = 1'b1;
        step();

        run_window(0, 0, 0,   8'd0,   -1, 1'b0);
        run_window(0, 1, 256, 8'd255, 0,  1'b0);
        run_window(0, 1, 64,  8'd64,  255, 1'b0);
        run_window(0, 2, 0,   8'd128, 64, 1'b0);
        run_window(0, 1, 256, 8'd255, 128, 1'b0);
        run_window(0, 2, 0,   8'd128, 255, 1'b0);

        // Abort in RUN cycle 100: no result, previous data kept.
        drive_start(0, 1'b1);
        step();
        drive_start(0, 1'b0);
        step();
        for (int k = 0; k < 100; k++) begin
            stim_bit = 1'b1;
            step();
        end
        stim_clr = 1'b1;
        step();
        stim_clr = 1'b0;
        stim_bit = 1'b0;
        check("clr_busy_drop", 32'(if0.oBusy), 32'd0);
        check("clr_data_kept", 32'(if0.oData), 32'd128);
        idle_watch(0, 300, "clr_no_valid");

        // Clear beats start in IDLE.
        drive_start(0, 1'b1);
        stim_clr = 1'b1;
        step();
        drive_start(0, 1'b0);
        stim_clr = 1'b0;
        check("clr_start_no_load", 32'(if0.oLoad), 32'd0);
        check("clr_start_no_busy", 32'(if0.oBusy), 32'd0);
        step();

        // Asynchronous reset mid-RUN.
        drive_start(0, 1'b1);
        step();
        drive_start(0, 1'b0);
        step();
        for (int k = 0; k < 50; k++) begin
            stim_bit = 1'b1;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", 32'(if0.oData), 32'd0);
        check("arst_busy", 32'(if0.oBusy), 32'd0);
        check("arst_valid", 32'(if0.oValid), 32'd0);
        stim_bit = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_watch(0, 300, "arst_no_valid");

        // Start pulses during LOAD/RUN/DONE must not queue another conversion.
        run_window(0, 1, 64, 8'd64, 0, 1'b1);
        idle_watch(0, 300, "noisy_single_valid");

        run_window(1, 1, 512,  8'd128, 0,   1'b0);
        run_window(1, 1, 1023, 8'd255, 128, 1'b0);
        run_window(1, 1, 1024, 8'd255, 255, 1'b0);

        step();
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsc_bs2bin_acc.md
Name: dsc_bs2bin_acc

Overview:
- Downstream stage of the stochastic multipliers (e.g. the rotation-based unipolar multiplier). Converts their serial output bitstream back to a binary value.
- Counts ones in `iBit` over a fixed window of 2^WINLOG cycles, then scales and saturates the count to DATAWD bits.
- Emits a one-cycle `oLoad` pulse that drives the multiplier's `loadA`/`loadB`, so the window is aligned to the first valid product bit.
- Start/valid handshake toward the controlling logic.

Parameters:
- DATAWD, 8, width of the binary result `oData`.
- WINLOG, 8, log2 of the window length in cycles. Constraint: WINLOG >= DATAWD; elaboration error otherwise.

Ports:
- clk     in   1             clock, rising edge
- rst_n   in   1             asynchronous reset, active low
- iBit    in   1             stochastic bitstream from upstream multiplier (`oC`)
- start   in   1             request a conversion; sampled only in IDLE
- iClr    in   1             synchronous abort; returns to IDLE
- oLoad   out  1             one-cycle pulse to upstream `loadA`/`loadB`
- oBusy   out  1             high whenever state != IDLE
- oValid  out  1             one-cycle pulse when `oData` is updated
- oData   out  DATAWD        converted result; held until the next completed window

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE; acc=0; winCnt=0; oData=0; oLoad=0; oValid=0; oBusy=0.
- Internal registers:
  - acc: WINLOG+1 bits, holds 0..2^WINLOG.
  - winCnt: WINLOG bits.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 -> LOAD.
  - Otherwise stay.
- LOAD:
  - oLoad=1.
  - acc<=0, winCnt<=0.
  - Always -> RUN.
  - Upstream latches its operands on this edge, so its first valid bit appears in the first RUN cycle.
- RUN:
  - Every cycle: acc <= acc + iBit; winCnt <= winCnt + 1.
  - When winCnt == 2^WINLOG - 1: this is the last sample, so go to DONE and register oData <= scale(acc + iBit) on the same edge.
  - RUN lasts exactly 2^WINLOG cycles.
- DONE:
  - oValid=1 for this single cycle; oData carries the new value.
  - Always -> IDLE. A start seen during DONE is ignored.
- scale(n): if n == 2^WINLOG, result = 2^DATAWD - 1 (saturate); otherwise result = n >> (WINLOG - DATAWD), truncating.
- Latency: start sampled at edge t -> oLoad high during cycle t+1 -> RUN cycles t+2 .. t+1+2^WINLOG -> oValid high in cycle t+2+2^WINLOG.
- oBusy is high in LOAD, RUN and DONE.
- start while busy: ignored, not queued.
- iClr:
  - In any state: next state IDLE; acc and winCnt cleared.
  - No oValid pulse; oData retains its previous value.
  - iClr has priority over start and over window completion in the same cycle.
- Reset mid-operation: immediate return to reset values, including oData=0; no oValid pulse.
- Wrap-around: winCnt wraps naturally only at the RUN exit. acc cannot overflow because its width is WINLOG+1.
- Back-to-back conversions: start held high re-triggers from IDLE, one cycle after DONE. Period is 2^WINLOG + 3 cycles.

Test Plan:
- Default parameters, reset, start=1 for one cycle, iBit=0 for the whole window -> oLoad pulse at cycle t+1; oValid at t+258 with oData=0; oBusy low at t+259.
- iBit=1 for all 256 RUN cycles -> oData=255 (saturated); iBit=1 for exactly the first 64 RUN cycles -> oData=64.
- Alternating 1/0 starting with 1 -> oData=128. Then immediately re-start with all ones -> second oValid with oData=255, and oData holds 128 in between.
- iClr asserted in RUN cycle 100 with prior oData=128 -> oBusy drops next cycle; no oValid; oData stays 128. Also: iClr asserted with start in IDLE -> no oLoad.
- rst_n deasserted asynchronously mid-RUN -> oData=0, oBusy=0 immediately, no oValid. Start pulses during LOAD/RUN/DONE -> ignored, exactly one oValid per accepted start.
- WINLOG=10, DATAWD=8, 512 ones in a 1024-cycle window -> oData=128; 1023 ones -> oData=255 (1023>>2); 1024 ones -> oData=255 (saturated).
